branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Resolution end of the branch-prediction interface. Queues each prediction
//  issued by the global predictor. Compares it with the actual outcome from
//  the execute stage. On a mispredict, pulses 'update' back to the predictor.
//  Sits between IF (prediction issue) and EX (branch resolve) in the MIPS pipe.
// PARAMETERS
//  DEPTH        4   in-flight prediction queue entries (power of 2, >=2)
//  FLUSH_CYCLES 3   stall cycles held after a mispredict (>=1)
//  CNT_W        32  width of statistics counters
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  pred_valid     in   1       predictor issued a prediction this cycle
//  pred_taken     in   1       issued prediction (1 = taken)
//  pred_ready     out  1       queue can accept (count < DEPTH)
//  res_valid      in   1       EX resolves oldest outstanding branch
//  res_taken      in   1       actual outcome (1 = taken)
//  update         out  1       1-cycle mispredict pulse to predictor
//  flush          out  1       1-cycle pulse, kill wrong-path IF/ID
//  stall          out  1       high while in RECOVER
//  q_count        out  $clog2(DEPTH)+1  entries outstanding
//  err_overflow   out  1       sticky: push while full
//  err_underflow  out  1       sticky: resolve while empty
//  branch_cnt     out  CNT_W   resolved branches (BRU_STATS_EN only)
//  mispred_cnt    out  CNT_W   mispredicts (BRU_STATS_EN only)
// BEHAVIOUR
//  Reset: queue empty, state RUN, and all outputs 0 except pred_ready=1.
//  Queue: circular FIFO with wr/rd pointers and a count.
//   - Push when pred_valid & pred_ready & state==RUN.
//   - Pop when res_valid & q_count!=0 & state==RUN.
//   - Pointers wrap modulo DEPTH.
//   - Push and pop in the same cycle: both happen, count unchanged.
//   - pred_ready is !full only; a same-cycle pop does not admit a push when full.
//   - pred_valid while full: entry dropped, err_overflow set.
//   - res_valid while empty: ignored, err_underflow set.
//   - Error flags clear only on reset.
//  Compare: the head entry's pred_taken is compared with res_taken.
//   - Match: entry popped; no other effect.
//   - Mismatch: update=1 and flush=1 on the cycle after res_valid is sampled.
//     Both last exactly 1 cycle, registered.
//  FSM:
//   - RUN -> RECOVER on mismatch. On that transition the whole queue is
//     cleared: younger entries are wrong-path, count=0.
//   - RECOVER: stall=1 for FLUSH_CYCLES cycles, starting the same cycle as
//     update. pred_valid and res_valid are ignored, with no error flags.
//   - RECOVER -> RUN when the down-counter reaches 0. stall drops the next cycle.
//  A mispredict pulse is never merged or repeated. Exactly one update per mismatch.
//  Reset asserted mid-RECOVER: immediately back to the reset values above.
//  Any unknown (X) input is treated as 0. No X propagates to outputs.
// CONFIGURATION
//  BRU_STATS_EN defined:
//   - branch_cnt increments on every pop, mispred_cnt on every mismatch.
//   - Both saturate at all-ones and reset to 0.
//  BRU_STATS_EN undefined: both ports tied to 0 and no counter flops are built.
// TESTING
//  1. Reset, then push T,N,T, then resolve T,N,T.
//     -> no update, q_count 3->0, pred_ready=1 throughout.
//  2. Push N, then resolve T.
//     -> update=flush=1 for one cycle.
//     -> stall=1 for 3 cycles, then 0; q_count=0.
//     -> mispred_cnt=1 (STATS on).
//  3. Push 4 entries (DEPTH=4), then push a 5th.
//     -> pred_ready=0 and err_overflow=1; q_count stays 4.
//  4. Full queue, pred_valid & res_valid same cycle.
//     -> pop only, q_count=3.
//     -> with q_count=2: push+pop leaves count 2; pointers wrap correctly.
//  5. Push T,T,T, then resolve N.
//     -> queue cleared; resolves during stall are ignored.
//     -> res_valid after RECOVER with empty queue sets err_underflow.
//  6. Drop rst_n during RECOVER.
//     -> stall, update, flush and q_count are 0 asynchronously.
//     -> pred_ready=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolution end of the branch-prediction interface. Predictions issued in IF
// are queued in order; when EX resolves the oldest branch its actual outcome
// is compared with the queued prediction. A mismatch sends a one-cycle
// update/flush pulse, clears the (wrong-path) queue and stalls the front end
// for FLUSH_CYCLES cycles.
//
// Optional feature: define BRU_STATS_EN to build the saturating
// branch_cnt / mispred_cnt statistics counters. Without it both ports are
// tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     update,
  output logic                     flush,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err_overflow,
  output logic                     err_underflow,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = PW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // Unknown or high-impedance inputs behave as a clean 0.
  function automatic logic x_to_zero(input logic v);
    return (v === 1'b1);
  endfunction

  state_t          state_r;
  logic [FW-1:0]   rec_cnt_r;
  logic [DEPTH-1:0] mem_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;

  logic            pv_s;
  logic            pt_s;
  logic            rv_s;
  logic            rt_s;
  logic            full_s;
  logic            empty_s;
  logic            head_s;
  logic            push_s;
  logic            pop_s;
  logic            ovf_s;
  logic            udf_s;
  logic            mis_s;
  logic [QW-1:0]   next_count_s;

  // Sanitise inputs and decode this cycle's queue operations.
  always_comb begin
    pv_s    = x_to_zero(pred_valid);
    pt_s    = x_to_zero(pred_taken);
    rv_s    = x_to_zero(res_valid);
    rt_s    = x_to_zero(res_taken);
    full_s  = (q_count == QW'(DEPTH));
    empty_s = (q_count == {QW{1'b0}});
    head_s  = mem_r[rd_ptr_r];
    if (state_r == RUN) begin
      // A same-cycle pop never frees room for a push when full.
      push_s = pv_s & ~full_s;
      pop_s  = rv_s & ~empty_s;
      ovf_s  = pv_s & full_s;
      udf_s  = rv_s & empty_s;
    end else begin
      // Wrong-path traffic during recovery is silently discarded.
      push_s = 1'b0;
      pop_s  = 1'b0;
      ovf_s  = 1'b0;
      udf_s  = 1'b0;
    end
    mis_s = pop_s & (head_s != rt_s);
    case ({push_s, pop_s})
      2'b10:   next_count_s = q_count + QW'(1);
      2'b01:   next_count_s = q_count - QW'(1);
      default: next_count_s = q_count;
    endcase
  end

  // Queue storage, pointers, recovery FSM and the registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      rec_cnt_r  <= {FW{1'b0}};
      mem_r      <= {DEPTH{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      q_count    <= {QW{1'b0}};
      pred_ready <= 1'b1;
      update     <= 1'b0;
      flush      <= 1'b0;
      stall      <= 1'b0;
    end else begin
      update <= mis_s;
      flush  <= mis_s;
      case (state_r)
        RUN: begin
          if (mis_s) begin
            // Everything younger than the mispredicted branch is wrong-path.
            state_r    <= RECOVER;
            stall      <= 1'b1;
            rec_cnt_r  <= FW'(FLUSH_CYCLES - 1);
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            q_count    <= {QW{1'b0}};
            pred_ready <= 1'b1;
          end else begin
            if (push_s) begin
              mem_r[wr_ptr_r] <= pt_s;
              wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
              rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            q_count    <= next_count_s;
            pred_ready <= (next_count_s != QW'(DEPTH));
          end
        end
        RECOVER: begin
          if (rec_cnt_r == {FW{1'b0}}) begin
            state_r <= RUN;
            stall   <= 1'b0;
          end else begin
            rec_cnt_r <= rec_cnt_r - FW'(1);
          end
        end
        default: begin
          state_r <= RUN;
          stall   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (ovf_s) begin
        err_overflow <= 1'b1;
      end
      if (udf_s) begin
        err_underflow <= 1'b1;
      end
    end
  end

`ifdef BRU_STATS_EN
  // Saturating counters of resolved branches and mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= {CNT_W{1'b0}};
      mispred_cnt <= {CNT_W{1'b0}};
    end else begin
      if (pop_s && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mis_s && (mispred_cnt != {CNT_W{1'b1}})) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign branch_cnt  = {CNT_W{1'b0}};
  assign mispred_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit (DEPTH=4, FLUSH_CYCLES=3). A small
// behavioural model predicts each cycle's outputs; the prediction is queued
// on the scoreboard when inputs are driven and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int FLUSH = 3;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             pred_valid;
  logic             pred_taken;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic             update;
  logic             flush;
  logic             stall;
  logic [2:0]       q_count;
  logic             err_overflow;
  logic             err_underflow;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  branch_resolve_unit #(
    .DEPTH(DEPTH),
    .FLUSH_CYCLES(FLUSH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid),
    .res_taken(res_taken),
    .update(update),
    .flush(flush),
    .stall(stall),
    .q_count(q_count),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic upd;
    logic stl;
    int   cnt;
    logic rdy;
    logic ov;
    logic un;
    int   br;
    int   mis;
  } exp_t;

  exp_t sb[$];
  bit   mq[$];
  int   m_rec;
  bit   m_ov;
  bit   m_un;
  int   m_br;
  int   m_mis;
  int   tests;
  int   fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_rec = 0;
    m_ov  = 1'b0;
    m_un  = 1'b0;
    m_br  = 0;
    m_mis = 0;
  endtask

  // One clock of stimulus: drive, predict, clock, compare.
  task automatic cycle(input logic pv, input logic pt, input logic rv, input logic rt);
    exp_t e;
    exp_t g;
    bit   mis;
    bit   full;
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    mis = 1'b0;
    if (m_rec == 0) begin
      full = (mq.size() == DEPTH);
      if ((rv === 1'b1) && (mq.size() == 0)) m_un = 1'b1;
      if ((pv === 1'b1) && full) m_ov = 1'b1;
      if ((rv === 1'b1) && (mq.size() != 0)) begin
        m_br++;
        mis = (mq[0] != (rt === 1'b1));
        void'(mq.pop_front());
      end
      if ((pv === 1'b1) && !full) mq.push_back(pt === 1'b1);
      if (mis) begin
        m_mis++;
        mq.delete();
        m_rec = FLUSH;
      end
    end else begin
      m_rec--;
    end
    e.upd = mis;
    e.stl = (m_rec != 0);
    e.cnt = mq.size();
    e.rdy = (mq.size() != DEPTH);
    e.ov  = m_ov;
    e.un  = m_un;
    e.br  = m_br;
    e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      g = sb.pop_front();
      chk("update", 32'(update), 32'(g.upd));
      chk("flush", 32'(flush), 32'(g.upd));
      chk("stall", 32'(stall), 32'(g.stl));
      chk("q_count", 32'(q_count), 32'(g.cnt));
      chk("pred_ready", 32'(pred_ready), 32'(g.rdy));
      chk("err_overflow", 32'(err_overflow), 32'(g.ov));
      chk("err_underflow", 32'(err_underflow), 32'(g.un));
`ifdef BRU_STATS_EN
      chk("branch_cnt", branch_cnt, 32'(g.br));
      chk("mispred_cnt", mispred_cnt, 32'(g.mis));
`else
      chk("branch_cnt_off", branch_cnt, 32'd0);
      chk("mispred_cnt_off", mispred_cnt, 32'd0);
`endif
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_update"}, 32'(update), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_q_count"}, 32'(q_count), 32'd0);
    chk({tag, "_pred_ready"}, 32'(pred_ready), 32'd1);
    chk({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
    chk({tag, "_err_underflow"}, 32'(err_underflow), 32'd0);
    chk({tag, "_branch_cnt"}, branch_cnt, 32'd0);
    chk({tag, "_mispred_cnt"}, mispred_cnt, 32'd0);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    // 1: push T,N,T then resolve T,N,T (all correct)
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // 2: push N, resolve T -> mispredict, three stall cycles
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // 3: fill the queue, then a fifth push overflows
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // 4: full queue with push+pop -> pop only; then push+pop at count 2 wraps
    cycle(1'b1, 1'b1, 1'b1, mq[0]);
    cycle(1'b0, 1'b0, 1'b1, mq[0]);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, mq[0]);
    cycle(1'b0, 1'b0, 1'b1, mq[0]);
    cycle(1'b0, 1'b0, 1'b1, mq[0]);

    // 5: push T,T,T then resolve N; traffic during stall ignored; then underflow
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < FLUSH; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Unknown inputs behave as 0
    cycle(1'bx, 1'b1, 1'bx, 1'bx);
    cycle(1'b1, 1'bx, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // 6: reset asserted in the middle of recovery
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
